// File: rtl/stream_packer.sv
// Purpose : width-up packer; gathers RATIO = 2**RATIO_WIDTH input words into one wide word.
// Latency : out_valid rises the cycle after the edge that accepts the last word of a group.
// Backpr. : only the final word of a group stalls, while the held output is not taken.
//
// Ports:
//   clock, reset              sole clock; asynchronous active-high reset
//   in_valid/in_ready/in_data narrow input stream (in_ready never depends on in_valid)
//   out_valid/out_ready       registered wide output handshake
//   out_data/out_count        packed word (first word in the low bits) and its word count
//   flush/flush_ack           only with STREAM_PACKER_FLUSH_EN: emit a partial group
//
// Optional feature macro: STREAM_PACKER_FLUSH_EN
module stream_packer #(
    parameter int DATA_WIDTH  = 16,
    parameter int RATIO_WIDTH = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     in_valid,
    input  logic [DATA_WIDTH-1:0]                    in_data,
    output logic                                     in_ready,
`ifdef STREAM_PACKER_FLUSH_EN
    input  logic                                     flush,
    output logic                                     flush_ack,
`endif
    output logic                                     out_valid,
    output logic [DATA_WIDTH*(1<<RATIO_WIDTH)-1:0]   out_data,
    output logic [RATIO_WIDTH:0]                     out_count,
    input  logic                                     out_ready
);

    localparam int RATIO = 1 << RATIO_WIDTH;
    localparam logic [RATIO_WIDTH-1:0] FILL_LAST = RATIO_WIDTH'(RATIO - 1);

    // The last word of a group never lands in a slot: it goes straight into
    // the output register together with the RATIO-1 stored words.
    logic [RATIO-2:0][DATA_WIDTH-1:0] slots;
    logic [RATIO_WIDTH-1:0]           fill;

    logic                             out_free;
    logic                             in_xfer;
    logic                             flush_take;
    logic                             load;
    logic [RATIO-1:0][DATA_WIDTH-1:0] grp_dat;
    logic [RATIO_WIDTH:0]             grp_cnt;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (fill != FILL_LAST) || out_free;
    assign in_xfer  = in_valid && in_ready;

`ifdef STREAM_PACKER_FLUSH_EN
    // Nothing to flush when the accumulator is empty and no word arrives.
    assign flush_take = !reset && flush && out_free && ((fill != '0) || in_xfer);
    assign flush_ack  = flush_take;
`else
    assign flush_take = 1'b0;
`endif

    // A full-group completion implies out_free, since in_ready requires it at FILL_LAST.
    assign load = (in_xfer && (fill == FILL_LAST)) || flush_take;

    // Group assembled from the stored slots plus the same-cycle input word;
    // positions above the loaded words read as zero (only matters for flush).
    always_comb begin
        grp_dat = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (RATIO_WIDTH'(i) < fill) begin
                grp_dat[i] = slots[i];
            end
        end
        for (int i = 0; i < RATIO; i++) begin
            if (in_xfer && (RATIO_WIDTH'(i) == fill)) begin
                grp_dat[i] = in_data;
            end
        end
    end

    assign grp_cnt = {1'b0, fill} + {{RATIO_WIDTH{1'b0}}, in_xfer};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slots     <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load) begin
            // Loading while the old word is taken keeps out_valid high: no bubble.
            out_valid <= 1'b1;
            out_data  <= grp_dat;
            out_count <= grp_cnt;
            fill      <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_xfer) begin
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (fill == RATIO_WIDTH'(i)) begin
                        slots[i] <= in_data;
                    end
                end
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Purpose : self-checking bench for stream_packer (DATA_WIDTH=16, RATIO=4).
// Latency : n/a (bench); checks outputs at the falling edge of each cycle.
// Backpr. : drives random in_valid/out_ready; reference model tracks groups with queues.
module tb_stream_packer;

    localparam int DW    = 16;
    localparam int RW    = 2;
    localparam int RATIO = 1 << RW;

    logic                  clock;
    logic                  reset;
    logic                  in_valid;
    logic [DW-1:0]         in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DW*RATIO-1:0]   out_data;
    logic [RW:0]           out_count;
    logic                  out_ready;
`ifdef STREAM_PACKER_FLUSH_EN
    logic                  flush;
    logic                  flush_ack;
`endif

    stream_packer #(.DATA_WIDTH(DW), .RATIO_WIDTH(RW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef STREAM_PACKER_FLUSH_EN
        .flush     (flush),
        .flush_ack (flush_ack),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: words waiting to form a group, and finished groups
    // waiting to be taken by the consumer (head = what out_data must show).
    typedef struct {
        logic [63:0] dat;
        int          cnt;
    } grp_t;

    logic [DW-1:0] acc[$];
    grp_t          grps[$];
    bit            last_acc;

    task automatic close_group();
        grp_t g;
        g.dat = '0;
        foreach (acc[k]) g.dat[k*DW +: DW] = acc[k];
        g.cnt = acc.size();
        grps.push_back(g);
        acc.delete();
    endtask

    task automatic model_clear();
        acc.delete();
        grps.delete();
    endtask

    // One cycle: apply inputs after the rising edge, check at the falling
    // edge, then advance the model for the transfers of the coming edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        logic exp_vld, exp_rdy, exp_ack, in_x;
        @(posedge clock);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
`ifdef STREAM_PACKER_FLUSH_EN
        flush     = f;
`endif
        @(negedge clock);
        exp_vld = (grps.size() > 0);
        exp_rdy = !((acc.size() == RATIO - 1) && exp_vld && !r);
        check("out_valid", 64'(out_valid), 64'(exp_vld));
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (exp_vld) begin
            check("out_data", out_data, grps[0].dat);
            check("out_count", 64'(out_count), 64'(grps[0].cnt));
        end
        in_x     = v && exp_rdy;
        last_acc = in_x;
        if (exp_vld && r) void'(grps.pop_front());
        exp_ack = 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
        exp_ack = f && (!exp_vld || r) && ((acc.size() != 0) || in_x);
        check("flush_ack", 64'(flush_ack), 64'(exp_ack));
`endif
        if (in_x) acc.push_back(d);
        if ((acc.size() == RATIO) || exp_ack) close_group();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] nxt;
        int            guard;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
        flush     = 1'b0;
`endif
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef STREAM_PACKER_FLUSH_EN
        check("rst_flush_ack", 64'(flush_ack), 64'd0);
`endif
        #1 reset = 1'b0;
        model_clear();

        // Sustained streaming, consumer always ready.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: the fourth word of the second group must stall.
        for (int w = 9; w <= 15; w++) step(1'b1, DW'(w), 1'b0, 1'b0);
        step(1'b1, 16'd16, 1'b0, 1'b0);
        step(1'b1, 16'd16, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with a held group and a partial one.
        for (int w = 'h20; w <= 'h25; w++) step(1'b1, DW'(w), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_out_count", 64'(out_count), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        model_clear();
        @(posedge clock);
        #2 reset = 1'b0;
        for (int w = 'h10; w <= 'h13; w++) step(1'b1, DW'(w), 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("post_rst_group", out_data, 64'h0013_0012_0011_0010);
        step(1'b0, '0, 1'b1, 1'b0);

        // Random handshakes with a running counter as data.
        nxt = 16'h0100;
        for (int c = 0; c < 2500; c++) begin
            step(($urandom_range(0, 3) != 0), nxt, ($urandom_range(0, 2) != 0), 1'b0);
            if (last_acc) nxt = nxt + 1'b1;
        end
        guard = 0;
        while ((grps.size() > 0) && (guard < 10)) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        check("drain_empty", 64'(grps.size()), 64'd0);

`ifdef STREAM_PACKER_FLUSH_EN
        in_valid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        model_clear();
        @(posedge clock);
        #2 reset = 1'b0;

        step(1'b1, 16'h00A1, 1'b1, 1'b0);
        step(1'b1, 16'h00A2, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("flush_part_data", out_data, 64'h0000_0000_00A2_00A1);
        check("flush_part_count", 64'(out_count), 64'd2);
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, 16'h00B1, 1'b1, 1'b0);
        step(1'b1, 16'h00B2, 1'b1, 1'b0);
        step(1'b1, 16'h00B3, 1'b1, 1'b0);
        step(1'b1, 16'h00B4, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("flush_full_data", out_data, 64'h00B4_00B3_00B2_00B1);
        check("flush_full_count", 64'(out_count), 64'd4);
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
